// File: rtl/plugboard_stage_if.sv
// Stream and rotor handshake bundle for the plugboard front end.
// master: plugboard side, slave: source/rotor/sink side.
interface plugboard_stage_if;
  logic       in_valid;
  logic [7:0] in_char;
  logic       in_ready;
  logic       rot_valid;
  logic [7:0] rot_din;
  logic       rot_done;
  logic [7:0] rot_dout;
  logic       out_valid;
  logic [7:0] out_char;

  modport master (
    input  in_valid,
    input  in_char,
    output in_ready,
    output rot_valid,
    output rot_din,
    input  rot_done,
    input  rot_dout,
    output out_valid,
    output out_char
  );

  modport slave (
    output in_valid,
    output in_char,
    input  in_ready,
    input  rot_valid,
    input  rot_din,
    output rot_done,
    output rot_dout,
    input  out_valid,
    input  out_char
  );
endinterface

// File: rtl/plugboard_stage.sv
// Enigma plugboard: input FIFO, letter-pair swap, rotor sequencer.
// One character in flight; non-letters bypass the rotor in order.
module plugboard_stage #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cfg_we,
  input  logic [7:0] cfg_a,
  input  logic [7:0] cfg_b,
  input  logic       cfg_clr,
  output logic       cfg_err,
  output logic       busy,
  output logic       timeout_err,
  plugboard_stage_if.master bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    EMIT
  } state_t;

  function automatic logic is_letter(input logic [7:0] c);
    return (c >= 8'd65) && (c <= 8'd90);
  endfunction

  function automatic logic [4:0] idx5(input logic [7:0] c);
    return is_letter(c) ? 5'(c - 8'd65) : 5'd0;
  endfunction

  logic [4:0] map_q [26];

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [7:0]    head;

  state_t        state_q;
  state_t        state_d;
  logic [7:0]    cur_q;
  logic [7:0]    cur_d;
  logic          pend_q;
  logic          pend_d;
  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;
  logic          tmo;
  logic          tmo_hit;

  logic          rot_valid_q;
  logic          rot_valid_d;
  logic [7:0]    rot_din_q;
  logic [7:0]    rot_din_d;
  logic          out_valid_q;
  logic          out_valid_d;
  logic [7:0]    out_char_q;
  logic [7:0]    out_char_d;

  logic [7:0]    head_sw;
  logic [7:0]    dout_sw;
  logic [4:0]    ai;
  logic [4:0]    bi;
  logic          cfg_ok;
  logic          clr_eff;

  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign push  = bus.in_valid && !full;
  assign head  = mem[rd_ptr];
  assign busy  = (state_q != IDLE) || !empty;

  assign bus.in_ready  = !full;
  assign bus.rot_valid = rot_valid_q;
  assign bus.rot_din   = rot_din_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_char  = out_char_q;

  assign head_sw = 8'(map_q[idx5(head)]) + 8'd65;
  assign dout_sw = 8'(map_q[idx5(bus.rot_dout)]) + 8'd65;

  assign ai = idx5(cfg_a);
  assign bi = idx5(cfg_b);
  assign cfg_ok = cfg_we && !busy
               && is_letter(cfg_a) && is_letter(cfg_b)
               && (cfg_a != cfg_b)
               && (map_q[ai] == ai) && (map_q[bi] == bi);
  assign clr_eff = cfg_clr && !busy;

  assign tmo_hit = (TIMEOUT != 0) && (cnt_q == TMAX)
                && !bus.rot_done;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_char;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 26; i++) map_q[i] <= 5'(i);
      cfg_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (clr_eff) begin
        for (int i = 0; i < 26; i++) map_q[i] <= 5'(i);
      end else if (cfg_ok) begin
        map_q[ai] <= bi;
        map_q[bi] <= ai;
      end
      cfg_err     <= cfg_we && !clr_eff && !cfg_ok;
      timeout_err <= !clr_eff && (timeout_err || tmo);
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    pend_d      = pend_q;
    cnt_d       = cnt_q;
    pop         = 1'b0;
    tmo         = 1'b0;
    rot_valid_d = 1'b0;
    rot_din_d   = 8'd0;
    out_valid_d = 1'b0;
    out_char_d  = out_char_q;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop   = 1'b1;
          cur_d = head;
          if (is_letter(head)) begin
            state_d     = ISSUE;
            rot_valid_d = 1'b1;
            rot_din_d   = head_sw;
          end else begin
            state_d = EMIT;
            pend_d  = 1'b1;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        unique case (1'b1)
          bus.rot_done: begin
            out_valid_d = 1'b1;
            out_char_d  = is_letter(bus.rot_dout)
                        ? dout_sw : bus.rot_dout;
            pend_d      = 1'b0;
            state_d     = EMIT;
          end
          tmo_hit: begin
            tmo     = 1'b1;
            state_d = IDLE;
          end
          default: cnt_d = cnt_q + 1'b1;
        endcase
      end
      EMIT: begin
        // bypass chars strobe here; rotor results already strobed
        out_valid_d = pend_q;
        if (pend_q) out_char_d = cur_q;
        pend_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cur_q       <= 8'd0;
      pend_q      <= 1'b0;
      cnt_q       <= '0;
      rot_valid_q <= 1'b0;
      rot_din_q   <= 8'd0;
      out_valid_q <= 1'b0;
      out_char_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      rot_valid_q <= rot_valid_d;
      rot_din_q   <= rot_din_d;
      out_valid_q <= out_valid_d;
      out_char_q  <= out_char_d;
    end
  end

endmodule

// File: tb/tb_plugboard_stage.sv
// Directed bench for plugboard_stage with a behavioural rotor.
// Rotor model: Caesar shift by 16, or a fixed reply.
module tb_plugboard_stage;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic       cfg_clr = 1'b0;
  logic [7:0] cfg_a = 8'd0;
  logic [7:0] cfg_b = 8'd0;
  logic       cfg_err;
  logic       busy;
  logic       timeout_err;

  plugboard_stage_if bus();

  plugboard_stage #(
    .FIFO_DEPTH(4),
    .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .cfg_we(cfg_we),
    .cfg_a(cfg_a),
    .cfg_b(cfg_b),
    .cfg_clr(cfg_clr),
    .cfg_err(cfg_err),
    .busy(busy),
    .timeout_err(timeout_err),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  logic       rot_en = 1'b1;
  int         rot_lat = 3;
  logic       use_fixed = 1'b0;
  logic [7:0] fixed_val = 8'd0;

  logic [7:0] out_q [$];
  int         out_t [$];
  logic [7:0] rd_q [$];
  int         rd_t [$];

  function automatic logic [7:0] shift16(input logic [7:0] c);
    return 8'((int'(c) - 65 + 16) % 26 + 65);
  endfunction

  initial begin
    logic [7:0] d;
    bus.rot_done = 1'b0;
    bus.rot_dout = 8'd0;
    forever begin
      @(negedge clk);
      if (bus.rot_valid && rot_en) begin
        d = bus.rot_din;
        repeat (rot_lat - 1) @(negedge clk);
        bus.rot_dout = use_fixed ? fixed_val : shift16(d);
        bus.rot_done = 1'b1;
        @(negedge clk);
        bus.rot_done = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.out_valid) begin
      out_q.push_back(bus.out_char);
      out_t.push_back(cyc);
    end
    if (bus.rot_valid) begin
      rd_q.push_back(bus.rot_din);
      rd_t.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  task automatic clear_q();
    out_q.delete();
    out_t.delete();
    rd_q.delete();
    rd_t.delete();
  endtask

  int t_push;

  task automatic push(input logic [7:0] c);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_char  = c;
    @(posedge clk);
    #1;
    t_push = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic cfg(input logic [7:0] a, input logic [7:0] b,
                     input logic exp_err, input string name);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_a  = a;
    cfg_b  = b;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    @(negedge clk);
    check(name, int'(cfg_err), int'(exp_err));
    @(negedge clk);
    check({name, "_pulse"}, int'(cfg_err), 0);
  endtask

  task automatic check_outs(input string name);
    check({name, "_rot_valid"}, int'(bus.rot_valid), 0);
    check({name, "_rot_din"}, int'(bus.rot_din), 0);
    check({name, "_out_valid"}, int'(bus.out_valid), 0);
    check({name, "_out_char"}, int'(bus.out_char), 0);
    check({name, "_cfg_err"}, int'(cfg_err), 0);
    check({name, "_timeout_err"}, int'(timeout_err), 0);
    check({name, "_busy"}, int'(busy), 0);
    check({name, "_in_ready"}, int'(bus.in_ready), 1);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       err;
  } cfg_vec_t;

  typedef struct {
    logic [7:0] c;
    logic       rv;
    logic [7:0] rd;
    logic [7:0] o;
  } chr_vec_t;

  cfg_vec_t cv [7];
  chr_vec_t xv [10];
  logic [7:0] sv [6];
  logic [7:0] sx [6];

  initial begin
    int idx;
    int drop_at;
    int guard;
    int t0;

    // identity start: A-B ok, then C-Z ok; everything else rejected
    cv[0] = '{8'h41, 8'h42, 1'b0};
    cv[1] = '{8'h42, 8'h43, 1'b1};
    cv[2] = '{8'h44, 8'h44, 1'b1};
    cv[3] = '{8'h5A, 8'h5B, 1'b1};
    cv[4] = '{8'h61, 8'h43, 1'b1};
    cv[5] = '{8'h43, 8'h5A, 1'b0};
    cv[6] = '{8'h5A, 8'h44, 1'b1};

    // plugs A-B, C-Z; rotor shift 16
    xv[0] = '{8'h41, 1'b1, 8'h42, 8'h52};
    xv[1] = '{8'h42, 1'b1, 8'h41, 8'h51};
    xv[2] = '{8'h43, 1'b1, 8'h5A, 8'h50};
    xv[3] = '{8'h4B, 1'b1, 8'h4B, 8'h42};
    xv[4] = '{8'h4A, 1'b1, 8'h4A, 8'h43};
    xv[5] = '{8'h5A, 1'b1, 8'h43, 8'h53};
    xv[6] = '{8'h35, 1'b0, 8'h00, 8'h35};
    xv[7] = '{8'h40, 1'b0, 8'h00, 8'h40};
    xv[8] = '{8'h5B, 1'b0, 8'h00, 8'h5B};
    xv[9] = '{8'h61, 1'b0, 8'h00, 8'h61};

    sv[0] = 8'h44; sx[0] = 8'h54;
    sv[1] = 8'h45; sx[1] = 8'h55;
    sv[2] = 8'h46; sx[2] = 8'h56;
    sv[3] = 8'h47; sx[3] = 8'h57;
    sv[4] = 8'h48; sx[4] = 8'h58;
    sv[5] = 8'h49; sx[5] = 8'h59;

    bus.in_valid = 1'b0;
    bus.in_char  = 8'd0;

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_outs("reset");

    // letter latency, identity map
    clear_q();
    push(8'h41);
    wait_idle();
    check("lat_rot_cnt", rd_q.size(), 1);
    check("lat_out_cnt", out_q.size(), 1);
    if (rd_q.size() == 1) begin
      check("lat_rot_din", int'(rd_q[0]), 8'h41);
      check("lat_rot_cyc", rd_t[0], t_push + 1);
    end
    if (out_q.size() == 1) begin
      check("lat_out_char", int'(out_q[0]), 8'h51);
      check("lat_out_cyc", out_t[0], t_push + 4);
    end

    // bypass latency
    clear_q();
    push(8'h35);
    wait_idle();
    check("byp_rot_cnt", rd_q.size(), 0);
    check("byp_out_cnt", out_q.size(), 1);
    if (out_q.size() == 1) begin
      check("byp_out_char", int'(out_q[0]), 8'h35);
      check("byp_out_cyc", out_t[0], t_push + 2);
    end

    for (int i = 0; i < 7; i++) begin
      cfg(cv[i].a, cv[i].b, cv[i].err, $sformatf("cfg%0d", i));
    end

    for (int i = 0; i < 10; i++) begin
      clear_q();
      push(xv[i].c);
      wait_idle();
      check($sformatf("vec%0d_out_cnt", i), out_q.size(), 1);
      if (out_q.size() == 1)
        check($sformatf("vec%0d_out", i), int'(out_q[0]), int'(xv[i].o));
      check($sformatf("vec%0d_rot_cnt", i), rd_q.size(), int'(xv[i].rv));
      if (xv[i].rv && rd_q.size() == 1)
        check($sformatf("vec%0d_rot_din", i), int'(rd_q[0]), int'(xv[i].rd));
    end

    // rotor returns fixed letter / non-letter
    use_fixed = 1'b1;
    fixed_val = 8'h41;
    clear_q();
    push(8'h41);
    wait_idle();
    check("fix_rot_din", rd_q.size() > 0 ? int'(rd_q[0]) : -1, 8'h42);
    check("fix_out", out_q.size() > 0 ? int'(out_q[0]) : -1, 8'h42);
    fixed_val = 8'h37;
    clear_q();
    push(8'h43);
    wait_idle();
    check("raw_out", out_q.size() > 0 ? int'(out_q[0]) : -1, 8'h37);
    use_fixed = 1'b0;

    // cfg while busy is rejected and map unchanged
    clear_q();
    push(8'h44);
    cfg(8'h44, 8'h45, 1'b1, "cfg_busy");
    wait_idle();
    clear_q();
    push(8'h44);
    wait_idle();
    check("busy_map_rot", rd_q.size() > 0 ? int'(rd_q[0]) : -1, 8'h44);
    check("busy_map_out", out_q.size() > 0 ? int'(out_q[0]) : -1, 8'h54);

    // ordering of mixed bypass and rotor chars
    clear_q();
    push(8'h35);
    push(8'h41);
    push(8'h21);
    wait_idle();
    check("ord_cnt", out_q.size(), 3);
    check("ord_rot_cnt", rd_q.size(), 1);
    if (out_q.size() == 3) begin
      check("ord0", int'(out_q[0]), 8'h35);
      check("ord1", int'(out_q[1]), 8'h52);
      check("ord2", int'(out_q[2]), 8'h21);
    end

    // timeout with a dead rotor
    rot_en = 1'b0;
    clear_q();
    push(8'h44);
    t0 = t_push;
    push(8'h35);
    guard = 0;
    while (!timeout_err && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("tmo_cyc", cyc, t0 + 10);
    wait_idle();
    check("tmo_flag", int'(timeout_err), 1);
    check("tmo_out_cnt", out_q.size(), 1);
    if (out_q.size() == 1)
      check("tmo_out", int'(out_q[0]), 8'h35);
    @(negedge clk);
    cfg_clr = 1'b1;
    @(posedge clk);
    #1;
    cfg_clr = 1'b0;
    @(negedge clk);
    check("clr_tmo", int'(timeout_err), 0);
    check("clr_cfg_err", int'(cfg_err), 0);
    rot_en = 1'b1;
    clear_q();
    push(8'h41);
    wait_idle();
    check("clr_map_rot", rd_q.size() > 0 ? int'(rd_q[0]) : -1, 8'h41);
    check("clr_map_out", out_q.size() > 0 ? int'(out_q[0]) : -1, 8'h51);

    // stalled rotor with in_valid held: backpressure
    rot_lat = 6;
    clear_q();
    idx = 0;
    drop_at = -1;
    guard = 0;
    while (idx < 6 && guard < 200) begin
      @(negedge clk);
      guard++;
      bus.in_valid = 1'b1;
      bus.in_char  = sv[idx];
      if (!bus.in_ready && drop_at < 0) drop_at = idx;
      if (bus.in_ready) begin
        @(posedge clk);
        idx++;
      end
    end
    #1;
    bus.in_valid = 1'b0;
    check("stall_pushed", idx, 6);
    check("stall_drop_at", drop_at, 5);
    wait_idle();
    check("stall_out_cnt", out_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < out_q.size())
        check($sformatf("stall_out%0d", i), int'(out_q[i]), int'(sx[i]));
    end
    rot_lat = 3;

    // reset while waiting on the rotor with 2 queued
    cfg(8'h41, 8'h42, 1'b0, "cfg_pre_rst");
    rot_en = 1'b0;
    clear_q();
    push(8'h41);
    push(8'h42);
    push(8'h43);
    repeat (2) @(negedge clk);
    check("pre_rst_busy", int'(busy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_outs("mid_rst");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    clear_q();
    repeat (20) @(negedge clk);
    check("post_rst_out", out_q.size(), 0);
    check("post_rst_rot", rd_q.size(), 0);
    rot_en = 1'b1;
    push(8'h41);
    wait_idle();
    check("post_rst_map", rd_q.size() > 0 ? int'(rd_q[0]) : -1, 8'h41);
    check("post_rst_out1", out_q.size() > 0 ? int'(out_q[0]) : -1, 8'h51);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/plugboard_stage.md
Name: plugboard_stage

Overview:
- Enigma plugboard (Steckerbrett) and front-end sequencer that sits directly upstream of the rotor chain.
- Buffers incoming ASCII characters and applies the programmable letter-pair swap.
- Issues one character at a time to the rotor with a valid pulse, waits for the rotor's done, then applies the same swap to the returned letter.
- Emits the final ciphertext/plaintext character with a one-cycle valid.

Parameters:
FIFO_DEPTH, 4, input buffer entries; power of two, at least 2.
TIMEOUT, 1024, max cycles spent in WAIT for rot_done before abandoning the character; 0 disables the timeout.

Ports:
clk  input  1  clock, all state updates on the rising edge
reset_n  input  1  asynchronous, active-low reset
cfg_we  input  1  add plug pair (cfg_a, cfg_b)
cfg_a  input  8  ASCII uppercase letter
cfg_b  input  8  ASCII uppercase letter
cfg_clr  input  1  restore identity mapping
cfg_err  output  1  one-cycle pulse: cfg_we rejected
in_valid  input  1  input character valid
in_char  input  8  input ASCII character
in_ready  output  1  FIFO can accept (combinational: not full)
rot_valid  output  1  one-cycle pulse to rotor valid
rot_din  output  8  swapped letter to rotor din
rot_done  input  1  rotor result valid (one-cycle pulse)
rot_dout  input  8  rotor result letter
out_valid  output  1  one-cycle output strobe
out_char  output  8  final character
busy  output  1  FSM not IDLE or FIFO non-empty
timeout_err  output  1  sticky, set on WAIT timeout; cleared by reset or cfg_clr

Behaviour:
- Reset values:
  - Map is identity.
  - FIFO is empty; in_ready=1.
  - rot_valid=0, rot_din=0, out_valid=0, out_char=0.
  - cfg_err=0, timeout_err=0, busy=0.
  - FSM is in IDLE.
- Reset mid-operation discards the FIFO contents and any in-flight character.
- All outputs except in_ready and busy are registered.
- Map: 26 entries of 5 bits each; letter L maps to map[L-65]+65.
- Configuration is accepted only when busy=0.
- A cfg_we is accepted when:
  - cfg_a and cfg_b are both in 'A'..'Z';
  - cfg_a != cfg_b;
  - both letters are currently self-mapped.
- On an accepted cfg_we, map[a]=b and map[b]=a take effect next cycle.
- Any other cfg_we (including cfg_we while busy=1) produces a cfg_err pulse on the next cycle and leaves the map unchanged.
- cfg_clr has priority over cfg_we in the same cycle: the map is reset to identity, no cfg_err pulse, and timeout_err is cleared. cfg_clr is ignored while busy=1.
- FIFO push occurs when in_valid && in_ready. in_ready depends only on full-before-pop, so a push while full is refused even if a pop happens in the same cycle.
- FSM:
  - IDLE: if the FIFO is non-empty, pop the head into cur. If cur is in 'A'..'Z', go to ISSUE; otherwise go to EMIT with out_char=cur (bypass, order preserved).
  - ISSUE: rot_valid=1 and rot_din=map[cur] for exactly one cycle; go to WAIT and clear the timeout counter.
  - WAIT: on rot_done=1, if rot_dout is a letter capture map[rot_dout], else capture rot_dout raw; go to EMIT. If the counter reaches TIMEOUT (and TIMEOUT != 0), set timeout_err, drop the character and return to IDLE.
  - EMIT: out_valid=1 for one cycle with out_char; then IDLE.
- rot_done outside WAIT is ignored.
- Only one character is in flight at a time.
- Latency (push on edge N):
  - Letter: rot_valid is high in the cycle after edge N+1; out_valid is high in the cycle after the edge that samples rot_done.
  - Bypass: out_valid is high in the cycle after edge N+2.
- Back-to-back: at most one output per 4 cycles plus the rotor latency.

Test Plan:
- Reset, no plugs, push 'A', rotor model returns 'Q' after 3 cycles -> rot_din='A', out_char='Q', one out_valid pulse.
- cfg_we A/B, then cfg_we B/C -> second produces cfg_err pulse; push 'A' -> rot_din='B'; rotor returns 'A' -> out_char='B'.
- Push '5', 'A', '!' -> out_char sequence '5', (rotor result), '!' in order; non-letters never raise rot_valid.
- Hold in_valid for 6 chars with rotor stalled -> in_ready drops after 4 accepted pushes plus the one popped; no loss or duplication after the rotor resumes.
- Rotor never asserts done, TIMEOUT=8 -> timeout_err set 8 cycles after entering WAIT; next FIFO char is processed; cfg_clr clears the flag.
- Assert reset_n=0 while in WAIT with 2 chars queued -> all outputs 0, in_ready=1, map identity, no out_valid after release.
